// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory
// wait freezes for a five-stage pipeline, with stall/flush performance counters.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_rd,
  input  logic             EXMEM_Branch,
  input  logic             EXMEM_Zero,
  input  logic             EXMEM_MemRead,
  input  logic             EXMEM_MemWrite,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IDEX_Bubble,
  output logic             MEMWB_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             PCSrc,
  output logic [1:0]       state,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       err_set;
  logic       flush_ev;
  logic       mem_pend;
  logic       taken;
  logic       loaduse;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign mem_pend = (EXMEM_MemRead | EXMEM_MemWrite) & ~mem_ready;
  assign taken    = EXMEM_Branch & EXMEM_Zero;
  assign loaduse  = IDEX_MemRead & (IDEX_rd != 5'd0) &
                    ((IDEX_rd == IFID_rs1) | (IDEX_rd == IFID_rs2));
  assign state    = cur_state;

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    EXMEM_Write  = 1'b1;
    IDEX_Bubble  = 1'b0;
    MEMWB_Bubble = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Flush  = 1'b0;
    PCSrc        = 1'b0;
    nxt_state    = RUN;
    wait_nxt     = 8'd0;
    err_set      = 1'b0;
    flush_ev     = 1'b0;
    if (!reset) begin
      // Clear every stage register on the same edges the controller is held in reset.
      PC_Write     = 1'b0;
      MEMWB_Bubble = 1'b1;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      EXMEM_Flush  = 1'b1;
    end else begin
      unique case (cur_state)
        RUN: begin
          if (mem_pend) begin
            {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write} = 4'b0000;
            MEMWB_Bubble = 1'b1;
            nxt_state    = MEM_WAIT;
            // The entry cycle is itself frozen, so it is the first counted wait cycle.
            wait_nxt     = 8'd1;
          end else if (taken) begin
            PCSrc       = 1'b1;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            flush_ev    = 1'b1;
            nxt_state   = FLUSH;
          end else if (loaduse) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            nxt_state = RUN;
          end else if (wait_cnt >= TIMEOUT_LAST) begin
            err_set   = 1'b1;
            nxt_state = RUN;
          end else begin
            {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write} = 4'b0000;
            MEMWB_Bubble = 1'b1;
            nxt_state    = MEM_WAIT;
            wait_nxt     = wait_cnt + 8'd1;
          end
        end
        FLUSH: begin
          if (mem_pend) begin
            {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write} = 4'b0000;
            MEMWB_Bubble = 1'b1;
            nxt_state    = MEM_WAIT;
            wait_nxt     = 8'd1;
          end
        end
        default: nxt_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_state   <= RUN;
      wait_cnt    <= 8'd0;
      mem_error   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
      if (err_set) mem_error <= 1'b1;
      if (!PC_Write) stall_count <= sat_inc(stall_count);
      if (flush_ev) flush_count <= sat_inc(flush_count);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: single-cycle decision table plus
// multi-cycle sequences for memory wait, timeout, reset abort and counter saturation.
module tb_hazard_control_unit;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    IFID_rs1, IFID_rs2, IDEX_rd;
  logic          IDEX_MemRead, EXMEM_Branch, EXMEM_Zero, EXMEM_MemRead, EXMEM_MemWrite, mem_ready;
  logic          PC_Write, IFID_Write, IDEX_Write, EXMEM_Write;
  logic          IDEX_Bubble, MEMWB_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc;
  logic [1:0]    state;
  logic          mem_error;
  logic [CW-1:0] stall_count, flush_count;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
    .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .mem_ready(mem_ready),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write), .EXMEM_Write(EXMEM_Write),
    .IDEX_Bubble(IDEX_Bubble), .MEMWB_Bubble(MEMWB_Bubble),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .PCSrc(PCSrc), .state(state), .mem_error(mem_error),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  // {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IDEX_Bubble, MEMWB_Bubble,
  //  IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc}
  logic [9:0] outs;
  assign outs = {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IDEX_Bubble, MEMWB_Bubble,
                 IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc};

  localparam logic [9:0] DEF  = 10'b1111000000;
  localparam logic [9:0] LU   = 10'b0011100000;
  localparam logic [9:0] FLS  = 10'b1111001111;
  localparam logic [9:0] FRZ  = 10'b0000010000;
  localparam logic [9:0] RSTO = 10'b0111011110;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       idmr;
    logic [4:0] rd;
    logic       br;
    logic       zr;
    logic       mr;
    logic       mw;
    logic       rdy;
    logic [9:0] exp_outs;
    logic [1:0] exp_nst;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    IFID_rs1 = 5'd0; IFID_rs2 = 5'd0; IDEX_MemRead = 1'b0; IDEX_rd = 5'd0;
    EXMEM_Branch = 1'b0; EXMEM_Zero = 1'b0; EXMEM_MemRead = 1'b0; EXMEM_MemWrite = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DEF, 2'd0};
    tbl[1]  = '{5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU,  2'd0};
    tbl[2]  = '{5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU,  2'd0};
    tbl[3]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DEF, 2'd0};
    tbl[4]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DEF, 2'd0};
    tbl[5]  = '{5'd6, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DEF, 2'd0};
    tbl[6]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FLS, 2'd2};
    tbl[7]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DEF, 2'd0};
    tbl[8]  = '{5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FLS, 2'd2};
    tbl[9]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 2'd1};
    tbl[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 2'd1};
    tbl[11] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, DEF, 2'd0};
    tbl[12] = '{5'd9, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FRZ, 2'd1};
    tbl[13] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, FLS, 2'd2};

    idle_inputs();
    reset = 1'b0;
    #1;
    chk("reset_comb_outs", 32'(outs), 32'(RSTO));
    tick();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_stall_cnt", 32'(stall_count), 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);
    chk("reset_mem_error", 32'(mem_error), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_reset();
      IFID_rs1 = tbl[i].rs1; IFID_rs2 = tbl[i].rs2;
      IDEX_MemRead = tbl[i].idmr; IDEX_rd = tbl[i].rd;
      EXMEM_Branch = tbl[i].br; EXMEM_Zero = tbl[i].zr;
      EXMEM_MemRead = tbl[i].mr; EXMEM_MemWrite = tbl[i].mw; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_outs", i), 32'(outs), 32'(tbl[i].exp_outs));
      tick();
      chk($sformatf("row%0d_next_state", i), 32'(state), 32'(tbl[i].exp_nst));
      chk($sformatf("row%0d_stall_cnt", i), 32'(stall_count), tbl[i].exp_outs[9] ? 32'd0 : 32'd1);
      chk($sformatf("row%0d_flush_cnt", i), 32'(flush_count), tbl[i].exp_outs[0] ? 32'd1 : 32'd0);
    end

    // Branch together with load-use: flush wins, FLUSH ignores both next cycle.
    do_reset();
    EXMEM_Branch = 1'b1; EXMEM_Zero = 1'b1;
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd4; IFID_rs1 = 5'd4;
    #1;
    chk("br_lu_outs", 32'(outs), 32'(FLS));
    tick();
    chk("br_lu_state_flush", 32'(state), 32'd2);
    chk("flush_cycle_outs", 32'(outs), 32'(DEF));
    tick();
    chk("br_lu_state_run", 32'(state), 32'd0);
    chk("br_lu_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_lu_stall_cnt", 32'(stall_count), 32'd0);

    // Memory ready after three frozen cycles.
    do_reset();
    EXMEM_MemRead = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("wait_outs_c%0d", i + 1), 32'(outs), 32'(FRZ));
      chk($sformatf("wait_state_c%0d", i + 1), 32'(state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("wait_release_outs", 32'(outs), 32'(DEF));
    chk("wait_release_state", 32'(state), 32'd1);
    tick();
    idle_inputs();
    #1;
    chk("wait_after_state", 32'(state), 32'd0);
    chk("wait_stall_cnt", 32'(stall_count), 32'd3);
    chk("wait_no_error", 32'(mem_error), 32'd0);

    // Timeout with MEM_TIMEOUT=4: three frozen cycles, released on the fourth.
    do_reset();
    EXMEM_MemRead = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("tmo_outs_c%0d", i + 1), 32'(outs), (i < 3) ? 32'(FRZ) : 32'(DEF));
      chk($sformatf("tmo_state_c%0d", i + 1), 32'(state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    idle_inputs();
    chk("tmo_state_after", 32'(state), 32'd0);
    chk("tmo_error_set", 32'(mem_error), 32'd1);
    chk("tmo_stall_cnt", 32'(stall_count), 32'd3);
    tick(); tick(); tick();
    chk("tmo_error_sticky", 32'(mem_error), 32'd1);

    // Reset asserted in the middle of a memory wait.
    EXMEM_MemWrite = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    chk("abort_wait_state", 32'(state), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_wait_outs", 32'(outs), 32'(RSTO));
    tick();
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("abort_wait_state_run", 32'(state), 32'd0);
    chk("abort_wait_stall_cnt", 32'(stall_count), 32'd0);
    chk("abort_wait_error_clr", 32'(mem_error), 32'd0);
    chk("abort_wait_run_outs", 32'(outs), 32'(DEF));

    // Reset asserted in FLUSH.
    EXMEM_Branch = 1'b1; EXMEM_Zero = 1'b1;
    tick();
    chk("abort_flush_state", 32'(state), 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("abort_flush_state_run", 32'(state), 32'd0);
    chk("abort_flush_cnt_clr", 32'(flush_count), 32'd0);
    chk("abort_flush_run_outs", 32'(outs), 32'(DEF));

    // Counter saturation at 4 bits.
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd12; IFID_rs2 = 5'd12;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_sat", 32'(stall_count), 32'd15);
    chk("stall_sat_state", 32'(state), 32'd0);

    do_reset();
    EXMEM_Branch = 1'b1; EXMEM_Zero = 1'b1;
    for (int i = 0; i < 34; i++) tick();
    chk("flush_sat", 32'(flush_count), 32'd15);
    chk("flush_sat_no_stall", 32'(stall_count), 32'd0);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
